fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline, directly upstream of instruction memory. It owns the program counter and drives the byte address into instruction memory. It captures the returned word into the IF/ID pipeline register. It handles stalls, branch/jump redirects, a post-reset boot cycle, and a halt on `syscall` or an out-of-range PC.

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage.
// Owns the program counter and drives it to instruction memory as a byte address.
// The returned word is captured into the IF/ID pipeline register.
// Handles stalls, branch/jump redirects and a one-cycle boot after reset.
// Fetch halts on syscall or when the PC leaves the text window.
//
// Parameters:
//   RESET_PC      byte address loaded into the PC on reset
//   TEXT_BYTES    size of the legal text window starting at RESET_PC
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   stall         hazard hold; PC and IF/ID keep their values
//   branch_taken  redirect to branch_target (wins over jump)
//   branch_target branch byte address
//   jump          redirect to jump_target
//   jump_target   jump byte address
//   pc_out        registered PC, instruction-memory address
//   instr_in      instruction word, combinational from pc_out
//   if_id_instr   latched instruction
//   if_id_pc4     latched PC+4 of that instruction
//   if_id_valid   IF/ID holds a real instruction
//   halted        fetch has stopped (sticky until reset)
//   fault         PC left the text window (sticky until reset)
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] TEXT_BYTES = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] Syscall = 32'h0000_000C;
    // Window end computed in 33 bits so a window touching 2^32 cannot wrap.
    localparam logic [32:0] TextEnd = {1'b0, RESET_PC} + {1'b0, TEXT_BYTES};

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic        out_of_range;

    assign pc_plus4     = pc_q + 32'd4;
    assign out_of_range = (pc_q < RESET_PC) || ({1'b0, pc_q} >= TextEnd);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (branch_taken || jump) begin
                    // Redirect overrides stall; targets are forced word-aligned.
                    pc_d    = branch_taken ? {branch_target[31:2], 2'b00}
                                           : {jump_target[31:2], 2'b00};
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (stall) begin
                    // Everything holds.
                end else if (out_of_range) begin
                    fault_d  = 1'b1;
                    halted_d = 1'b1;
                    state_d  = StHalt;
                    instr_d  = '0;
                    pc4_d    = '0;
                    valid_d  = 1'b0;
                end else if (instr_in == Syscall) begin
                    // The syscall itself retires; the PC stays on it.
                    instr_d  = instr_in;
                    pc4_d    = pc_plus4;
                    valid_d  = 1'b1;
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end else begin
                    instr_d = instr_in;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                end
            end
            StHalt: begin
                // IF/ID drains on the first non-stalled edge, then stays empty.
                if (!stall) begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StBoot;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign pc_out      = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: table of per-edge stimulus and expected outputs,
// scoreboarded through a queue, plus hand-written window-boundary sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic        fault;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_out       (pc_out),
        .instr_in     (instr_in),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fault        (fault)
    );

    // Instruction memory: two fixed words, a syscall at 0x00400010,
    // otherwise 0x2400_<low address half>.
    always_comb begin
        instr_in = {16'h2400, pc_out[15:0]};
        if (pc_out == 32'h0040_0000)      instr_in = 32'h2008_0001;
        else if (pc_out == 32'h0040_0004) instr_in = 32'h2009_0002;
        else if (pc_out == 32'h0040_0010) instr_in = 32'h0000_000C;
    end

    typedef struct {
        string       name;
        logic        rst;
        logic        stl;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halt;
        logic        flt;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(string n, logic r, logic s, logic b, logic [31:0] bt,
                                logic j, logic [31:0] jt, logic [31:0] pc,
                                logic [31:0] ins, logic [31:0] p4, logic v, logic h,
                                logic f);
        vec_t x;
        x.name = n; x.rst = r; x.stl = s; x.br = b; x.bt = bt; x.jmp = j; x.jt = jt;
        x.pc = pc; x.instr = ins; x.pc4 = p4; x.valid = v; x.halt = h; x.flt = f;
        return x;
    endfunction

    task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Drive one vector, push its expectation, then pop and compare after the edge.
    task automatic apply(vec_t v);
        vec_t e;
        @(negedge clk);
        reset         = v.rst;
        stall         = v.stl;
        branch_taken  = v.br;
        branch_target = v.bt;
        jump          = v.jmp;
        jump_target   = v.jt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected entry for %s", v.name);
        end else begin
            e = sb.pop_front();
            chk(e.name, "pc_out", pc_out, e.pc);
            chk(e.name, "if_id_instr", if_id_instr, e.instr);
            chk(e.name, "if_id_pc4", if_id_pc4, e.pc4);
            chk(e.name, "if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
            chk(e.name, "halted", {31'b0, halted}, {31'b0, e.halt});
            chk(e.name, "fault", {31'b0, fault}, {31'b0, e.flt});
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0;

        //               name         r  s  b  bt            j  jt            pc            instr         pc4           v  h  f
        vecs.push_back(mk("reset0",   1, 0, 0, 32'h0,       0, 32'h0,       32'h0040_0000, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk("reset1",   1, 0, 0, 32'h0,       0, 32'h0,       32'h0040_0000, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk("boot",     0, 0, 1, 32'h0040_0200, 1, 32'h0,     32'h0040_0000, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk("fetch0",   0, 0, 0, 32'h0,       0, 32'h0,       32'h0040_0004, 32'h2008_0001, 32'h0040_0004, 1, 0, 0));
        vecs.push_back(mk("fetch1",   0, 0, 0, 32'h0,       0, 32'h0,       32'h0040_0008, 32'h2009_0002, 32'h0040_0008, 1, 0, 0));
        vecs.push_back(mk("stall0",   0, 1, 0, 32'h0,       0, 32'h0,       32'h0040_0008, 32'h2009_0002, 32'h0040_0008, 1, 0, 0));
        vecs.push_back(mk("stall1",   0, 1, 0, 32'h0,       0, 32'h0,       32'h0040_0008, 32'h2009_0002, 32'h0040_0008, 1, 0, 0));
        vecs.push_back(mk("stall2",   0, 1, 0, 32'h0,       0, 32'h0,       32'h0040_0008, 32'h2009_0002, 32'h0040_0008, 1, 0, 0));
        vecs.push_back(mk("resume",   0, 0, 0, 32'h0,       0, 32'h0,       32'h0040_000C, 32'h2400_0008, 32'h0040_000C, 1, 0, 0));
        vecs.push_back(mk("br_vs_j",  0, 1, 1, 32'h0040_0103, 1, 32'h0040_0200, 32'h0040_0100, 32'h0,    32'h0,        0, 0, 0));
        vecs.push_back(mk("br_tgt",   0, 0, 0, 32'h0,       0, 32'h0,       32'h0040_0104, 32'h2400_0100, 32'h0040_0104, 1, 0, 0));
        vecs.push_back(mk("jump_sys", 0, 0, 0, 32'h0,       1, 32'h0040_0010, 32'h0040_0010, 32'h0,      32'h0,        0, 0, 0));
        vecs.push_back(mk("syscall",  0, 0, 0, 32'h0,       0, 32'h0,       32'h0040_0010, 32'h0000_000C, 32'h0040_0014, 1, 1, 0));
        vecs.push_back(mk("hlt_stl",  0, 1, 0, 32'h0,       0, 32'h0,       32'h0040_0010, 32'h0000_000C, 32'h0040_0014, 1, 1, 0));
        vecs.push_back(mk("hlt_drn",  0, 0, 0, 32'h0,       1, 32'h0040_0200, 32'h0040_0010, 32'h0,      32'h0,        0, 1, 0));
        vecs.push_back(mk("hlt_br",   0, 0, 1, 32'h0040_0300, 0, 32'h0,     32'h0040_0010, 32'h0,        32'h0,        0, 1, 0));
        vecs.push_back(mk("rst_hlt",  1, 0, 0, 32'h0,       0, 32'h0,       32'h0040_0000, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk("boot2",    0, 0, 0, 32'h0,       0, 32'h0,       32'h0040_0000, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk("refetch",  0, 0, 0, 32'h0,       0, 32'h0,       32'h0040_0004, 32'h2008_0001, 32'h0040_0004, 1, 0, 0));
        vecs.push_back(mk("jump_0",   0, 0, 0, 32'h0,       1, 32'h0,       32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk("fault_lo", 0, 0, 0, 32'h0,       0, 32'h0,       32'h0,         32'h0,        32'h0,        0, 1, 1));
        vecs.push_back(mk("flt_jmp",  0, 0, 0, 32'h0,       1, 32'h0040_0000, 32'h0,       32'h0,        32'h0,        0, 1, 1));
        vecs.push_back(mk("rst_flt",  1, 0, 0, 32'h0,       0, 32'h0,       32'h0040_0000, 32'h0,        32'h0,        0, 0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Upper window boundary: last legal word fetches, the next address faults.
        apply(mk("boot3",    0, 0, 0, 32'h0, 0, 32'h0,         32'h0040_0000, 32'h0, 32'h0, 0, 0, 0));
        apply(mk("jump_top", 0, 0, 0, 32'h0, 1, 32'h0040_3FFE, 32'h0040_3FFC, 32'h0, 32'h0, 0, 0, 0));
        apply(mk("last_wd",  0, 0, 0, 32'h0, 0, 32'h0,
                 32'h0040_4000, 32'h2400_3FFC, 32'h0040_4000, 1, 0, 0));
        apply(mk("fault_hi", 0, 0, 0, 32'h0, 0, 32'h0,         32'h0040_4000, 32'h0, 32'h0, 0, 1, 1));
        apply(mk("flt_hold", 0, 1, 0, 32'h0, 0, 32'h0,         32'h0040_4000, 32'h0, 32'h0, 0, 1, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
